// File: rtl/dpu_sched.sv
// Two-requester round-robin scheduler for a shared DPU: registers the granted
// command onto the DPU inputs, waits SETTLE cycles, then returns the sampled result.
module dpu_sched #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [12:0] req0_cmd,
    input  logic [12:0] req1_cmd,
    output logic [15:0] dpu_din,
    output logic [1:0]  dpu_dsel,
    input  logic [7:0]  dpu_dout,
    input  logic [6:0]  dpu_seg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic [6:0]  rsp_seg,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; ready never depends on anything but state, valids and last grant.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        winner;
    logic        accept;
    logic [12:0] win_cmd;

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
        req0_ready = (state == S_IDLE) && req0_valid && !winner;
        req1_ready = (state == S_IDLE) && req1_valid && winner;
        accept     = req0_ready || req1_ready;
        win_cmd    = winner ? req1_cmd : req0_cmd;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == 4'd0) state_nxt = S_RESP;
            S_RESP:   if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            dpu_din    <= 16'd0;
            dpu_dsel   <= 2'd0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_seg    <= 7'd0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dpu_din    <= {5'b0, win_cmd[10:0]};
                dpu_dsel   <= win_cmd[12:11];
                rsp_id     <= winner;
                last_grant <= winner;
            end
            if (state == S_ISSUE) begin
                cnt <= SETTLE_LOAD;
            end
            if (state == S_SETTLE) begin
                if (cnt == 4'd0) begin
                    rsp_data  <= dpu_dout;
                    rsp_seg   <= dpu_seg;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dpu_sched.sv
// Directed bench for dpu_sched: three instances (SETTLE = 2, 1, 15) share one
// stimulus set and a simple DPU model; expected values are hand-computed.
module tb_dpu_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [12:0] req0_cmd, req1_cmd;
    logic        rsp_ready;
    logic [7:0]  dpu_dout;
    logic [6:0]  dpu_seg;
    logic        ovr;
    logic [7:0]  ovr_dout;
    logic [6:0]  ovr_seg;

    logic        r0_a, r1_a, rv_a, rid_a, busy_a;
    logic [15:0] din_a;
    logic [1:0]  dsel_a, dbg_a;
    logic [7:0]  rdata_a;
    logic [6:0]  rseg_a;

    logic        r0_b, r1_b, rv_b, rid_b, busy_b;
    logic [15:0] din_b;
    logic [1:0]  dsel_b, dbg_b;
    logic [7:0]  rdata_b;
    logic [6:0]  rseg_b;

    logic        r0_c, r1_c, rv_c, rid_c, busy_c;
    logic [15:0] din_c;
    logic [1:0]  dsel_c, dbg_c;
    logic [7:0]  rdata_c;
    logic [6:0]  rseg_c;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [12:0] tbl [10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] f_dout(input logic [12:0] c);
        return c[7:0] ^ {c[12:11], c[10:8], 3'b101};
    endfunction

    function automatic logic [6:0] f_seg(input logic [12:0] c);
        return {c[10:8], c[3:0]};
    endfunction

    // DPU model: combinational function of the SETTLE=2 instance's DPU inputs.
    assign dpu_dout = ovr ? ovr_dout : f_dout({dsel_a, din_a[10:0]});
    assign dpu_seg  = ovr ? ovr_seg  : f_seg({dsel_a, din_a[10:0]});

    dpu_sched #(.SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(r0_a), .req1_ready(r1_a),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .dpu_din(din_a), .dpu_dsel(dsel_a),
        .dpu_dout(dpu_dout), .dpu_seg(dpu_seg),
        .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_id(rid_a),
        .rsp_data(rdata_a), .rsp_seg(rseg_a),
        .busy(busy_a), .dbg_state(dbg_a)
    );

    dpu_sched #(.SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(r0_b), .req1_ready(r1_b),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .dpu_din(din_b), .dpu_dsel(dsel_b),
        .dpu_dout(dpu_dout), .dpu_seg(dpu_seg),
        .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_id(rid_b),
        .rsp_data(rdata_b), .rsp_seg(rseg_b),
        .busy(busy_b), .dbg_state(dbg_b)
    );

    dpu_sched #(.SETTLE(15)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(r0_c), .req1_ready(r1_c),
        .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
        .dpu_din(din_c), .dpu_dsel(dsel_c),
        .dpu_dout(dpu_dout), .dpu_seg(dpu_seg),
        .rsp_valid(rv_c), .rsp_ready(rsp_ready), .rsp_id(rid_c),
        .rsp_data(rdata_c), .rsp_seg(rseg_c),
        .busy(busy_c), .dbg_state(dbg_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_b, n_c, got_g, exp_g, t_prev, seen;
        bit zero_ok;
        logic [12:0] cmd_e;

        tbl = '{{2'd0, 3'd0, 4'd1, 4'd2}, {2'd3, 3'd1, 4'd7, 4'd9},
                {2'd2, 3'd2, 4'd4, 4'd6}, {2'd1, 3'd3, 4'hF, 4'h0},
                {2'd0, 3'd4, 4'hA, 4'h5}, {2'd3, 3'd5, 4'h3, 4'hC},
                {2'd1, 3'd6, 4'h8, 4'h1}, {2'd2, 3'd7, 4'hE, 4'hD},
                {2'd3, 3'd7, 4'hF, 4'hF}, {2'd0, 3'd1, 4'h2, 4'h4}};

        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_cmd = '0; req1_cmd = '0; rsp_ready = 1'b0;
        ovr = 1'b0; ovr_dout = '0; ovr_seg = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din",   32'(din_a),   32'h0);
        chk("rst_dsel",  32'(dsel_a),  32'h0);
        chk("rst_rv",    32'(rv_a),    32'h0);
        chk("rst_rid",   32'(rid_a),   32'h0);
        chk("rst_rdata", 32'(rdata_a), 32'h0);
        chk("rst_rseg",  32'(rseg_a),  32'h0);
        chk("rst_busy",  32'(busy_a),  32'h0);
        chk("rst_state", 32'(dbg_a),   32'h0);

        // Single request, accepted on the first edge after reset release
        rst_n = 1'b1;
        req0_cmd = {2'd1, 3'd2, 4'd5, 4'd3};
        req0_valid = 1'b1;
        ovr = 1'b1; ovr_dout = 8'h2A; ovr_seg = 7'h12;
        @(negedge clk);
        chk("single_rdy", 32'({r0_a, r1_a}), 32'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        chk("single_din",  32'(din_a),  32'h0253);
        chk("single_dsel", 32'(dsel_a), 32'h1);
        chk("single_busy", 32'(busy_a), 32'h1);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rv_a) begin n = i; break; end
        end
        chk("single_lat",   32'(n),       32'd3);
        chk("single_rid",   32'(rid_a),   32'h0);
        chk("single_rdata", 32'(rdata_a), 32'h2A);
        chk("single_rseg",  32'(rseg_a),  32'h12);

        // Backpressure in RESP with a competing request pending
        req1_cmd = tbl[1];
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rv",    32'(rv_a),           32'h1);
            chk("bp_rdata", 32'(rdata_a),        32'h2A);
            chk("bp_rdy",   32'({r0_a, r1_a}),   32'h0);
            chk("bp_din",   32'(din_a),          32'h0253);
        end
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_rv",    32'(rv_a),    32'h0);
        chk("hs_rdata", 32'(rdata_a), 32'h2A);
        chk("hs_rseg",  32'(rseg_a),  32'h12);
        chk("hs_busy",  32'(busy_a),  32'h0);

        // Tie after reset, back-to-back with rsp_ready high
        do_reset();
        ovr = 1'b0;
        req0_cmd = tbl[0];
        req1_cmd = tbl[1];
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        t_prev = 0;
        for (int op = 0; op < 8; op++) begin
            exp_g = op % 2;
            got_g = -1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (r0_a || r1_a) begin
                    got_g = r1_a ? 1 : 0;
                    break;
                end
            end
            chk("tie_onehot", 32'(r0_a & r1_a), 32'h0);
            chk("tie_grant",  32'(got_g),       32'(exp_g));
            if (op > 0) chk("b2b_spacing", 32'(cyc - t_prev), 32'd5);
            t_prev = cyc;
            cmd_e = (exp_g == 1) ? req1_cmd : req0_cmd;
            @(posedge clk);
            #1;
            chk("tie_din",  32'(din_a),  32'({5'b0, cmd_e[10:0]}));
            chk("tie_dsel", 32'(dsel_a), 32'(cmd_e[12:11]));
            if (exp_g == 0) req0_cmd = tbl[op + 2];
            else            req1_cmd = tbl[op + 2];
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (rv_a) begin seen = 1; break; end
            end
            chk("tie_rsp_seen", 32'(seen),    32'd1);
            chk("tie_rid",      32'(rid_a),   32'(exp_g));
            chk("tie_rdata",    32'(rdata_a), 32'(f_dout(cmd_e)));
            chk("tie_rseg",     32'(rseg_a),  32'(f_seg(cmd_e)));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset pulse during SETTLE
        @(posedge clk);
        #1;
        req1_cmd = tbl[4];
        req1_valid = 1'b1;
        @(posedge clk);
        #1 req1_valid = 1'b0;
        chk("mid_busy", 32'(busy_a), 32'h1);
        @(posedge clk);
        #1;
        chk("mid_in_settle", 32'(dbg_a), 32'h2);
        rst_n = 1'b0;
        #2;
        chk("mid_din",   32'(din_a),   32'h0);
        chk("mid_dsel",  32'(dsel_a),  32'h0);
        chk("mid_rv",    32'(rv_a),    32'h0);
        chk("mid_rid",   32'(rid_a),   32'h0);
        chk("mid_rdata", 32'(rdata_a), 32'h0);
        chk("mid_rseg",  32'(rseg_a),  32'h0);
        chk("mid_busy0", 32'(busy_a),  32'h0);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rv_a || busy_a) seen = 1;
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        req0_cmd = tbl[5];
        req0_valid = 1'b1;
        #1;
        chk("mid_next_rdy", 32'({r0_a, r1_a}), 32'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rv_a) begin n = i; break; end
        end
        chk("mid_next_lat",   32'(n),       32'd3);
        chk("mid_next_rdata", 32'(rdata_a), 32'(f_dout(tbl[5])));
        @(posedge clk);

        // SETTLE = 1 / 2 / 15 latency, upper dpu_din bits stay zero
        do_reset();
        req0_cmd = tbl[7];
        req0_valid = 1'b1;
        @(negedge clk);
        chk("par_rdy", 32'({r0_a, r0_b, r0_c}), 32'b111);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        n = 0; n_b = 0; n_c = 0; zero_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rv_a && n == 0)   n   = i;
            if (rv_b && n_b == 0) n_b = i;
            if (rv_c && n_c == 0) n_c = i;
            if (din_a[15:11] != 5'd0 || din_b[15:11] != 5'd0 || din_c[15:11] != 5'd0)
                zero_ok = 1'b0;
        end
        chk("par_lat_s1",  32'(n_b),     32'd2);
        chk("par_lat_s2",  32'(n),       32'd3);
        chk("par_lat_s15", 32'(n_c),     32'd16);
        chk("par_din_hi0", 32'(zero_ok), 32'd1);
        chk("par_din_s15", 32'(din_c),   32'({5'b0, tbl[7][10:0]}));
        chk("par_rdata_s15", 32'(rdata_c), 32'(f_dout(tbl[7])));
        chk("par_rdata_s1",  32'(rdata_b), 32'(f_dout(tbl[7])));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
